// File: rtl/inst_loader.sv
// Boot-time program loader: parses a framed byte stream, writes big-endian words into
// instruction memory, and releases the core only after the frame checksum matches.
module inst_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_run,
  output logic        done,
  output logic        error
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  SyncByte = 8'hA5;

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StData, StCsum, StDone, StErr
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       len_hi_q, len_hi_d;
  logic [15:0]      n_q, n_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [15:0]      word_idx_q, word_idx_d;
  logic [7:0]       sum_q, sum_d;
  logic [23:0]      word_q, word_d;
  logic [CntW-1:0]  idle_q, idle_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;

  logic        accept;
  logic        in_frame;
  logic [15:0] len_full;

  assign in_ready   = (state_q != StDone);
  assign done       = (state_q == StDone);
  assign cpu_run    = (state_q == StDone);
  assign error      = (state_q == StErr);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

  assign accept   = in_valid & in_ready;
  assign in_frame = (state_q == StLenHi) || (state_q == StLenLo) ||
                    (state_q == StData)  || (state_q == StCsum);
  assign len_full = {len_hi_q, in_data};

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    n_d        = n_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    sum_d      = sum_q;
    word_d     = word_q;
    idle_d     = '0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    // Inter-byte watchdog only runs while a frame is in progress.
    if (in_frame && !accept) begin
      idle_d = idle_q + CntW'(1);
      if (idle_d == CntW'(TIMEOUT)) begin
        state_d = StErr;
        idle_d  = '0;
      end
    end

    if (accept) begin
      unique case (state_q)
        StIdle, StErr: begin
          if (in_data == SyncByte) state_d = StLenHi;
        end
        StLenHi: begin
          len_hi_d = in_data;
          state_d  = StLenLo;
        end
        StLenLo: begin
          n_d        = len_full;
          byte_idx_d = '0;
          word_idx_d = '0;
          sum_d      = '0;
          if (32'(len_full) > MAX_WORDS) begin
            state_d = StErr;
          end else if (len_full == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
        StData: begin
          word_d     = {word_q[15:0], in_data};
          sum_d      = sum_q + in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d       = 1'b1;
            wdata_d    = {word_q, in_data};
            addr_d     = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
            word_idx_d = word_idx_q + 16'd1;
            if (word_idx_q == n_q - 16'd1) state_d = StCsum;
          end
        end
        StCsum: begin
          state_d = (in_data == sum_q) ? StDone : StErr;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      len_hi_q   <= '0;
      n_q        <= '0;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      sum_q      <= '0;
      word_q     <= '0;
      idle_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      n_q        <= n_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      sum_q      <= sum_d;
      word_q     <= word_d;
      idle_q     <= idle_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule
